// File: rtl/atm_pkg.sv
// Shared encodings for the ATM controller: FSM states, opcodes and error codes.
package atm_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_AUTH   = 3'd1;
    localparam logic [2:0] ST_MENU   = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;
    localparam logic [2:0] ST_EJECT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_AUTH   = ST_AUTH,
        S_MENU   = ST_MENU,
        S_EXEC   = ST_EXEC,
        S_RESULT = ST_RESULT,
        S_EJECT  = ST_EJECT
    } state_e;

    typedef enum logic [2:0] {
        OP_BALANCE  = 3'd0,
        OP_WITHDRAW = 3'd1,
        OP_DEPOSIT  = 3'd2,
        OP_TRANSFER = 3'd3,
        OP_CHPIN    = 3'd4,
        OP_EXIT     = 3'd5
    } opcode_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_PIN      = 3'd1;
    localparam logic [2:0] ERR_FUNDS    = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_LOCKED   = 3'd4;
    localparam logic [2:0] ERR_DEST     = 3'd5;
    localparam logic [2:0] ERR_OPCODE   = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd7;

endpackage

// File: rtl/atm_acct_bank.sv
// Per-account storage: balance, PIN, wrong-PIN tries and lock flag.
// Two balance write ports let a transfer update source and destination in one edge.
module atm_acct_bank
    import atm_pkg::*;
#(
    parameter int ID_W  = 2,
    parameter int PIN_W = 4,
    parameter int BAL_W = 8,
    parameter int TRY_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ID_W-1:0]  ra_id,
    output logic [BAL_W-1:0] ra_bal,
    output logic [PIN_W-1:0] ra_pin,
    output logic [TRY_W-1:0] ra_tries,
    output logic             ra_lock,
    input  logic [ID_W-1:0]  rb_id,
    output logic [BAL_W-1:0] rb_bal,
    input  logic [ID_W-1:0]  wa_id,
    input  logic             wa_bal_en,
    input  logic [BAL_W-1:0] wa_bal,
    input  logic             wa_pin_en,
    input  logic [PIN_W-1:0] wa_pin,
    input  logic             wa_try_en,
    input  logic [TRY_W-1:0] wa_tries,
    input  logic             wa_lock_en,
    input  logic [ID_W-1:0]  wb_id,
    input  logic             wb_bal_en,
    input  logic [BAL_W-1:0] wb_bal
);

    localparam int DEPTH = 1 << ID_W;

    logic [BAL_W-1:0] bal_q  [DEPTH];
    logic [PIN_W-1:0] pin_q  [DEPTH];
    logic [TRY_W-1:0] try_q  [DEPTH];
    logic             lock_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bal_q[i]  <= '0;
                pin_q[i]  <= PIN_W'(i);
                try_q[i]  <= '0;
                lock_q[i] <= 1'b0;
            end
        end else begin
            if (wb_bal_en)  bal_q[wb_id]  <= wb_bal;
            if (wa_bal_en)  bal_q[wa_id]  <= wa_bal;
            if (wa_pin_en)  pin_q[wa_id]  <= wa_pin;
            if (wa_try_en)  try_q[wa_id]  <= wa_tries;
            if (wa_lock_en) lock_q[wa_id] <= 1'b1;
        end
    end

    assign ra_bal   = bal_q[ra_id];
    assign ra_pin   = pin_q[ra_id];
    assign ra_tries = try_q[ra_id];
    assign ra_lock  = lock_q[ra_id];
    assign rb_bal   = bal_q[rb_id];

endmodule

// File: rtl/atm_ctrl.sv
// ATM session controller: card/PIN authentication, menu handshake and account operations.
// Define ATM_TIMEOUT_EN to eject sessions idle for TIMEOUT_CYC cycles in AUTH or MENU.
module atm_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 4,
    parameter int PIN_W        = 4,
    parameter int BAL_W        = 8,
    parameter int MAX_TRIES    = 3,
    parameter int TIMEOUT_CYC  = 1024,
    localparam int ID_W        = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic [ID_W-1:0]  card_id,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_in,
    input  logic             exit_req,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       opcode,
    input  logic [BAL_W-1:0] amount,
    input  logic [ID_W-1:0]  dest_id,
    input  logic [PIN_W-1:0] new_pin,
    output logic [BAL_W-1:0] balance,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             locked,
    output logic [2:0]       state_o
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [2:0]       state_q;
    logic             card_q;
    logic [ID_W-1:0]  act_id_q;
    logic [2:0]       opc_q;
    logic [BAL_W-1:0] amt_q;
    logic [ID_W-1:0]  dest_q;
    logic [PIN_W-1:0] npin_q;

    logic [ID_W-1:0]  ra_id;
    logic [BAL_W-1:0] ra_bal, rb_bal;
    logic [PIN_W-1:0] ra_pin;
    logic [TRY_W-1:0] ra_tries, tries_inc;
    logic             ra_lock;

    logic             card_fall, pin_match, lock_now, auth_pin, exec_go, timeout;
    logic [BAL_W:0]   src_sum, dst_sum;
    logic             dest_bad;
    logic             exec_err, wr_src, wr_dst;
    logic [2:0]       exec_code;
    logic [BAL_W-1:0] new_src, new_dst;

    // In IDLE the presented card is looked up so a locked account is refused at once.
    assign ra_id     = (state_q == ST_IDLE) ? card_id : act_id_q;
    assign card_fall = card_q & ~card_in;
    assign pin_match = (pin_in == ra_pin);
    assign tries_inc = ra_tries + 1'b1;
    assign lock_now  = (tries_inc >= TRY_W'(MAX_TRIES));
    assign auth_pin  = (state_q == ST_AUTH) && !card_fall && !exit_req && pin_valid;
    assign exec_go   = (state_q == ST_EXEC) && !card_fall;

    assign op_ready  = (state_q == ST_MENU);
    assign locked    = ra_lock;
    assign state_o   = state_q;

    assign src_sum   = {1'b0, ra_bal} + {1'b0, amt_q};
    assign dst_sum   = {1'b0, rb_bal} + {1'b0, amt_q};
    assign dest_bad  = (dest_q == act_id_q) || ({1'b0, dest_q} >= (ID_W + 1)'(NUM_ACCOUNTS));

`ifdef ATM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            waiting, activity;

    assign waiting  = (state_q == ST_AUTH) || (state_q == ST_MENU);
    assign activity = pin_valid || (op_ready && op_valid);
    assign timeout  = waiting && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt_q <= '0;
        else if (!waiting || activity)
            to_cnt_q <= '0;
        else if (!timeout)
            to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    // Never true: sessions wait indefinitely in this build.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // Operation evaluation; every check is resolved before any write is enabled.
    always_comb begin
        exec_err  = 1'b0;
        exec_code = ERR_NONE;
        wr_src    = 1'b0;
        wr_dst    = 1'b0;
        new_src   = ra_bal;
        new_dst   = rb_bal;
        case (opcode_e'(opc_q))
            OP_BALANCE, OP_CHPIN, OP_EXIT: begin
            end
            OP_WITHDRAW: begin
                if (amt_q > ra_bal) begin
                    exec_err  = 1'b1;
                    exec_code = ERR_FUNDS;
                end else begin
                    new_src = ra_bal - amt_q;
                    wr_src  = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (src_sum[BAL_W]) begin
                    exec_err  = 1'b1;
                    exec_code = ERR_OVERFLOW;
                end else begin
                    new_src = src_sum[BAL_W-1:0];
                    wr_src  = 1'b1;
                end
            end
            OP_TRANSFER: begin
                if (dest_bad) begin
                    exec_err  = 1'b1;
                    exec_code = ERR_DEST;
                end else if (amt_q > ra_bal) begin
                    exec_err  = 1'b1;
                    exec_code = ERR_FUNDS;
                end else if (dst_sum[BAL_W]) begin
                    exec_err  = 1'b1;
                    exec_code = ERR_OVERFLOW;
                end else begin
                    new_src = ra_bal - amt_q;
                    new_dst = dst_sum[BAL_W-1:0];
                    wr_src  = 1'b1;
                    wr_dst  = 1'b1;
                end
            end
            default: begin
                exec_err  = 1'b1;
                exec_code = ERR_OPCODE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            card_q   <= 1'b0;
            act_id_q <= '0;
            opc_q    <= '0;
            amt_q    <= '0;
            dest_q   <= '0;
            npin_q   <= '0;
            balance  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            card_q   <= card_in;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            case (state_q)
                ST_IDLE: begin
                    if (card_in) begin
                        act_id_q <= card_id;
                        if (ra_lock) begin
                            state_q  <= ST_EJECT;
                            err      <= 1'b1;
                            err_code <= ERR_LOCKED;
                        end else begin
                            state_q <= ST_AUTH;
                        end
                    end
                end
                ST_AUTH: begin
                    if (card_fall || exit_req) begin
                        state_q <= ST_EJECT;
                    end else if (pin_valid) begin
                        if (pin_match) begin
                            state_q <= ST_MENU;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_PIN;
                            if (lock_now) state_q <= ST_EJECT;
                        end
                    end else if (timeout) begin
                        state_q  <= ST_EJECT;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_MENU: begin
                    if (card_fall || exit_req) begin
                        state_q <= ST_EJECT;
                    end else if (op_valid) begin
                        opc_q   <= opcode;
                        amt_q   <= amount;
                        dest_q  <= dest_id;
                        npin_q  <= new_pin;
                        state_q <= ST_EXEC;
                    end else if (timeout) begin
                        state_q  <= ST_EJECT;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_EXEC: begin
                    if (card_fall || opc_q == OP_EXIT) begin
                        state_q <= ST_EJECT;
                    end else begin
                        state_q  <= ST_RESULT;
                        done     <= 1'b1;
                        err      <= exec_err;
                        err_code <= exec_code;
                        balance  <= new_src;
                    end
                end
                ST_RESULT: state_q <= card_fall ? ST_EJECT : ST_MENU;
                ST_EJECT:  state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    atm_acct_bank #(
        .ID_W  (ID_W),
        .PIN_W (PIN_W),
        .BAL_W (BAL_W),
        .TRY_W (TRY_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .ra_id      (ra_id),
        .ra_bal     (ra_bal),
        .ra_pin     (ra_pin),
        .ra_tries   (ra_tries),
        .ra_lock    (ra_lock),
        .rb_id      (dest_q),
        .rb_bal     (rb_bal),
        .wa_id      (act_id_q),
        .wa_bal_en  (exec_go && wr_src),
        .wa_bal     (new_src),
        .wa_pin_en  (exec_go && opc_q == OP_CHPIN),
        .wa_pin     (npin_q),
        .wa_try_en  (auth_pin),
        .wa_tries   (pin_match ? '0 : tries_inc),
        .wa_lock_en (auth_pin && !pin_match && lock_now),
        .wb_id      (dest_q),
        .wb_bal_en  (exec_go && wr_dst),
        .wb_bal     (new_dst)
    );

endmodule

// File: tb/tb_atm_ctrl.sv
// Directed bench for atm_ctrl with a behavioural account model feeding a result scoreboard.
module tb_atm_ctrl;

    localparam int S_IDLE = 0, S_AUTH = 1, S_MENU = 2, S_EJECT = 5;
    localparam int O_BAL = 0, O_WD = 1, O_DEP = 2, O_XFER = 3, O_CHPIN = 4, O_EXIT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       card_in = 1'b0;
    logic [1:0] card_id = '0;
    logic       pin_valid = 1'b0;
    logic [3:0] pin_in = '0;
    logic       exit_req = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] opcode = '0;
    logic [7:0] amount = '0;
    logic [1:0] dest_id = '0;
    logic [3:0] new_pin = '0;
    logic [7:0] balance;
    logic       done, err, locked;
    logic [2:0] err_code, state_o;

    atm_ctrl #(
        .NUM_ACCOUNTS(4), .PIN_W(4), .BAL_W(8), .MAX_TRIES(3), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .card_id(card_id),
        .pin_valid(pin_valid), .pin_in(pin_in), .exit_req(exit_req),
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
        .amount(amount), .dest_id(dest_id), .new_pin(new_pin),
        .balance(balance), .done(done), .err(err), .err_code(err_code),
        .locked(locked), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       err;
        logic [2:0] code;
        logic [7:0] bal;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mbal[4];
    int   mpin[4];
    int   act = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic login(input int id, input int pin);
        card_id = 2'(id);
        card_in = 1'b1;
        act     = id;
        tick();
        pin_in    = 4'(pin);
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
    endtask

    // Model predicts the result, pushes it, then the DUT completion is popped and compared.
    task automatic do_op(input string tag, input int opc, input int amt, input int dst, input int np);
        exp_t e;
        bit   seen;
        e.tag = tag; e.err = 1'b0; e.code = 3'd0;
        case (opc)
            O_BAL: ;
            O_WD:  if (amt > mbal[act]) begin e.err = 1; e.code = 3'd2; end
                   else mbal[act] -= amt;
            O_DEP: if (mbal[act] + amt > 255) begin e.err = 1; e.code = 3'd3; end
                   else mbal[act] += amt;
            O_XFER: if (dst == act || dst >= 4) begin e.err = 1; e.code = 3'd5; end
                    else if (amt > mbal[act]) begin e.err = 1; e.code = 3'd2; end
                    else if (mbal[dst] + amt > 255) begin e.err = 1; e.code = 3'd3; end
                    else begin mbal[act] -= amt; mbal[dst] += amt; end
            O_CHPIN: mpin[act] = np;
            default: begin e.err = 1; e.code = 3'd6; end
        endcase
        e.bal = 8'(mbal[act]);
        exp_q.push_back(e);
        tick();
        opcode = 3'(opc); amount = 8'(amt); dest_id = 2'(dst); new_pin = 4'(np);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        e = exp_q.pop_front();
        if (!seen) check({e.tag, ".done"}, 32'(done), 32'd1);
        else begin
            check({e.tag, ".err"}, 32'(err), 32'(e.err));
            check({e.tag, ".code"}, 32'(err_code), 32'(e.code));
            check({e.tag, ".bal"}, 32'(balance), 32'(e.bal));
        end
    endtask

    task automatic exit_op(input string tag);
        tick();
        opcode = 3'(O_EXIT);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        card_in = 1'b0;
        @(negedge clk);
        check({tag, ".eject"}, 32'(state_o), S_EJECT);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin mbal[i] = 0; mpin[i] = i; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.state", 32'(state_o), S_IDLE);
        check("rst.op_ready", 32'(op_ready), 0);
        check("rst.done", 32'(done), 0);
        check("rst.err", 32'(err), 0);
        check("rst.err_code", 32'(err_code), 0);
        check("rst.balance", 32'(balance), 0);
        check("rst.locked", 32'(locked), 0);
        rst = 1'b0;

        login(1, mpin[1]);
        @(negedge clk);
        check("login1.state", 32'(state_o), S_MENU);
        check("login1.op_ready", 32'(op_ready), 1);
        do_op("dep50", O_DEP, 50, 0, 0);
        do_op("bal50", O_BAL, 0, 0, 0);
        do_op("wd60", O_WD, 60, 0, 0);
        do_op("wd0", O_WD, 0, 0, 0);
        do_op("illegal", 6, 0, 0, 0);
        do_op("dep_ovf", O_DEP, 250, 0, 0);
        do_op("chpin", O_CHPIN, 0, 0, 9);
        exit_op("exit1");

        login(1, 1);
        @(negedge clk);
        check("oldpin.err", 32'(err), 1);
        check("oldpin.code", 32'(err_code), 1);
        check("oldpin.state", 32'(state_o), S_AUTH);
        pin_in = 4'(mpin[1]);
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        @(negedge clk);
        check("newpin.state", 32'(state_o), S_MENU);
        do_op("dep130", O_DEP, 130, 0, 0);
        exit_op("exit2");

        login(0, mpin[0]);
        do_op("dep200", O_DEP, 200, 0, 0);
        do_op("xfer_ovf", O_XFER, 100, 1, 0);
        do_op("xfer50", O_XFER, 50, 1, 0);
        do_op("xfer_self", O_XFER, 10, 0, 0);
        do_op("xfer_funds", O_XFER, 200, 1, 0);
        exit_op("exit3");
        login(1, mpin[1]);
        do_op("bal_dest", O_BAL, 0, 0, 0);
        exit_op("exit4");

        card_id = 2'd2;
        card_in = 1'b1;
        act = 2;
        tick();
        for (int k = 1; k <= 3; k++) begin
            pin_in = 4'(mpin[2] + 1);
            pin_valid = 1'b1;
            tick();
            pin_valid = 1'b0;
            @(negedge clk);
            check($sformatf("badpin%0d.err", k), 32'(err), 1);
            check($sformatf("badpin%0d.code", k), 32'(err_code), 1);
            check($sformatf("badpin%0d.state", k), 32'(state_o), (k < 3) ? S_AUTH : S_EJECT);
            check($sformatf("badpin%0d.locked", k), 32'(locked), (k < 3) ? 0 : 1);
        end
        card_in = 1'b0;
        tick();
        card_in = 1'b1;
        tick();
        @(negedge clk);
        check("relock.state", 32'(state_o), S_EJECT);
        check("relock.err", 32'(err), 1);
        check("relock.code", 32'(err_code), 4);
        card_in = 1'b0;
        tick();

        login(3, mpin[3]);
        card_in = 1'b0;
        tick();
        @(negedge clk);
        check("cardpull.state", 32'(state_o), S_EJECT);
        tick();

        card_id = 2'd3;
        card_in = 1'b1;
        tick();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        card_in = 1'b0;
        @(negedge clk);
        check("exitreq.state", 32'(state_o), S_EJECT);
        tick();

        login(3, mpin[3]);
`ifdef ATM_TIMEOUT_EN
        repeat (15) tick();
        @(negedge clk);
        check("tmo.before", 32'(state_o), S_MENU);
        tick();
        @(negedge clk);
        check("tmo.state", 32'(state_o), S_EJECT);
        check("tmo.err", 32'(err), 1);
        check("tmo.code", 32'(err_code), 7);
        card_in = 1'b0;
        tick();
`else
        repeat (40) tick();
        @(negedge clk);
        check("notmo.state", 32'(state_o), S_MENU);
        exit_op("exit5");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
